// File: rtl/lsu_dram_if_if.sv
// Bundle of the LSU request/response handshake and the data-RAM port.
// slave = the LSU itself; master = core pipeline plus data memory around it.
interface lsu_dram_if_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [3:0]  req_we;
   logic [2:0]  req_ext_op;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;
   logic        dram_req;
   logic [31:0] dram_addr;
   logic [3:0]  dram_we;
   logic [31:0] dram_wdata;
   logic        dram_gnt;
   logic        dram_rvalid;
   logic [31:0] dram_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_ext_op, req_wdata,
      output dram_gnt, dram_rvalid, dram_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, stall,
      input  dram_req, dram_addr, dram_we, dram_wdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_ext_op, req_wdata,
      input  dram_gnt, dram_rvalid, dram_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, stall,
      output dram_req, dram_addr, dram_we, dram_wdata
   );
endinterface

// File: rtl/lsu_dram_if.sv
// LA32R load/store unit: store lane steering, load select/extend, alignment
// checking and a req/gnt/rvalid handshake to data RAM, stalling while busy.
module lsu_dram_if (
   input  logic          clk,
   input  logic          rst,
   lsu_dram_if_if.slave  bus
);
   localparam int unsigned DW   = 32;
   localparam int unsigned WEW  = 4;
   localparam int unsigned EXTW = 3;

   localparam logic [EXTW-1:0] RAM_EXT_N  = 3'd0;
   localparam logic [EXTW-1:0] RAM_EXT_B  = 3'd1;
   localparam logic [EXTW-1:0] RAM_EXT_BU = 3'd2;
   localparam logic [EXTW-1:0] RAM_EXT_H  = 3'd3;
   localparam logic [EXTW-1:0] RAM_EXT_HU = 3'd4;

   localparam logic [WEW-1:0] WE_LD = 4'b0000;
   localparam logic [WEW-1:0] WE_B  = 4'b0001;
   localparam logic [WEW-1:0] WE_H  = 4'b0011;
   localparam logic [WEW-1:0] WE_W  = 4'b1111;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   state_e          state_q, state_d;
   logic            req_ready_q, req_ready_d;
   logic            resp_valid_q, resp_valid_d;
   logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
   logic            resp_err_q, resp_err_d;
   logic            dram_req_q, dram_req_d;
   logic [DW-1:0]   dram_addr_q, dram_addr_d;
   logic [WEW-1:0]  dram_we_q, dram_we_d;
   logic [DW-1:0]   dram_wdata_q, dram_wdata_d;
   logic [1:0]      lo_q, lo_d;
   logic [EXTW-1:0] ext_q, ext_d;
   logic            load_q, load_d;

   logic            req_err_c;
   logic [DW-1:0]   steer_c;
   logic [7:0]      byte_c;
   logic [15:0]     half_c;
   logic [DW-1:0]   load_data_c;

   // Alignment / encoding check on the incoming request
   always_comb begin
      req_err_c = 1'b0;
      unique case (bus.req_we)
         WE_LD: begin
            unique case (bus.req_ext_op)
               RAM_EXT_H, RAM_EXT_HU: req_err_c = bus.req_addr[0];
               RAM_EXT_B, RAM_EXT_BU: req_err_c = 1'b0;
               default:               req_err_c = (bus.req_addr[1:0] != 2'b00);
            endcase
         end
         WE_B:    req_err_c = 1'b0;
         WE_H:    req_err_c = bus.req_addr[0];
         WE_W:    req_err_c = (bus.req_addr[1:0] != 2'b00);
         default: req_err_c = 1'b1;
      endcase
   end

   // Replicate store data across all lanes; byte enables select the live one
   always_comb begin
      steer_c = '0;
      unique case (bus.req_we)
         WE_B:    steer_c = {4{bus.req_wdata[7:0]}};
         WE_H:    steer_c = {2{bus.req_wdata[15:0]}};
         WE_W:    steer_c = bus.req_wdata;
         default: steer_c = '0;
      endcase
   end

   always_comb begin
      byte_c      = 8'(bus.dram_rdata >> {lo_q, 3'b000});
      half_c      = lo_q[1] ? bus.dram_rdata[31:16] : bus.dram_rdata[15:0];
      load_data_c = bus.dram_rdata;
      unique case (ext_q)
         RAM_EXT_B:  load_data_c = {{24{byte_c[7]}}, byte_c};
         RAM_EXT_BU: load_data_c = {24'd0, byte_c};
         RAM_EXT_H:  load_data_c = {{16{half_c[15]}}, half_c};
         RAM_EXT_HU: load_data_c = {16'd0, half_c};
         default:    load_data_c = bus.dram_rdata;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      dram_req_d   = dram_req_q;
      dram_addr_d  = dram_addr_q;
      dram_we_d    = dram_we_q;
      dram_wdata_d = dram_wdata_q;
      lo_d         = lo_q;
      ext_d        = ext_q;
      load_d       = load_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               lo_d   = bus.req_addr[1:0];
               ext_d  = bus.req_ext_op;
               load_d = (bus.req_we == WE_LD);
               if (req_err_c) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d      = S_REQ;
                  dram_req_d   = 1'b1;
                  dram_addr_d  = {bus.req_addr[31:2], 2'b00};
                  dram_we_d    = WEW'(bus.req_we << bus.req_addr[1:0]);
                  dram_wdata_d = steer_c;
               end
            end
         end
         S_REQ: begin
            if (bus.dram_gnt) begin
               dram_req_d   = 1'b0;
               dram_addr_d  = '0;
               dram_we_d    = '0;
               dram_wdata_d = '0;
               if (load_q) begin
                  state_d = S_WAIT;
               end else begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  resp_rdata_d = '0;
               end
            end
         end
         S_WAIT: begin
            if (bus.dram_rvalid) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = load_data_c;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         dram_req_q   <= 1'b0;
         dram_addr_q  <= '0;
         dram_we_q    <= '0;
         dram_wdata_q <= '0;
         lo_q         <= '0;
         ext_q        <= '0;
         load_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         dram_req_q   <= dram_req_d;
         dram_addr_q  <= dram_addr_d;
         dram_we_q    <= dram_we_d;
         dram_wdata_q <= dram_wdata_d;
         lo_q         <= lo_d;
         ext_q        <= ext_d;
         load_q       <= load_d;
      end
   end

   // Stall is combinational so a request is held in the same cycle it appears
   assign bus.stall = ((state_q == S_IDLE) && bus.req_valid) ||
                      (state_q == S_REQ) || (state_q == S_WAIT);

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.dram_req   = dram_req_q;
   assign bus.dram_addr  = dram_addr_q;
   assign bus.dram_we    = dram_we_q;
   assign bus.dram_wdata = dram_wdata_q;

endmodule

// File: doc/lsu_dram_if.md
# lsu_dram_if

Load/store unit sitting between the execute/memory stage and the data RAM port of the LA32R core. Consumes the decoder's store byte-enables (`ram_we`) and load-extension selector (`ram_ext_op`), and runs a request/grant/read-valid handshake with data memory. Performs store lane steering, load byte/half selection with sign/zero extension, and misalignment checking. Holds a pipeline stall while an access is in flight.

## Interface
- No parameters; address and data paths are fixed at 32 bits.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `req_valid`  in  1  memory-stage instruction is a load or store.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_addr`  in  32  byte address (ALU result).
- `req_we`  in  4  decoder `ram_we`, word-relative:
  - 0000 load
  - 0001 st.b
  - 0011 st.h
  - 1111 st.w
  - any other value illegal.
- `req_ext_op`  in  3  decoder `ram_ext_op` (`RAM_EXT_N`/`_B`/`_BU`/`_H`/`_HU` from defines.vh); loads only.
- `req_wdata`  in  32  store data (rd value), low-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`; misaligned or illegal `req_we`.
- `stall`  out  1  freeze upstream pipeline.
- `dram_req`  out  1  memory request, held until granted.
- `dram_addr`  out  32  word address, `{req_addr[31:2],2'b00}`.
- `dram_we`  out  4  lane byte enables; 0000 = read.
- `dram_wdata`  out  32  lane-steered store data.
- `dram_gnt`  in  1  memory accepted the request this cycle.
- `dram_rvalid`  in  1  read data valid.
- `dram_rdata`  in  32  read word.

## Operation
- States:
  - IDLE: on accept, go to REQ, or to RESP if the request errors.
  - REQ: `dram_req`=1. On `dram_gnt`, a store goes to RESP and a load goes to WAIT; otherwise stay in REQ.
  - WAIT: on `dram_rvalid`, capture the extended data and go to RESP.
  - RESP: `resp_valid`=1, then go to IDLE.
- Request capture: `addr`, `we`, `ext_op` and `wdata` are registered at accept. Inputs are don't-care afterwards.
- Error check at accept:
  - H/HU with addr[0]=1 is an error.
  - N load with addr[1:0]≠0 is an error.
  - st.h with addr[0]=1 is an error.
  - st.w with addr[1:0]≠0 is an error.
  - Any illegal `req_we` is an error.
  - An errored request performs no DRAM access.
- Store steering:
  - `dram_we = req_we << addr[1:0]`.
  - `dram_wdata` is `{4{wdata[7:0]}}` for a byte store, `{2{wdata[15:0]}}` for a half store, and `wdata` for a word store.
- Load select:
  - Byte = `rdata[8*addr[1:0] +: 8]`.
  - Half = `rdata[16*addr[1] +: 16]`.
  - B/H sign-extend; BU/HU zero-extend; N passes the word through.
- `stall = (state==IDLE && req_valid) || state==REQ || state==WAIT`. `stall` is 0 in RESP, so the pipeline advances in the same cycle the result is presented.
- `dram_rvalid` is ignored outside WAIT. `dram_gnt` is ignored outside REQ.

## Timing
- Reset values:
  - state IDLE.
  - `resp_valid`, `resp_err`, `dram_req` = 0.
  - `resp_rdata`, `dram_addr`, `dram_wdata` = 0.
  - `dram_we` = 0000.
  - `req_ready` = 1.
  - `stall` = `req_valid`.
- Cycle counts, with accept in cycle 0:
  - Best-case store: REQ+gnt in cycle 1, `resp_valid` in cycle 2.
  - Best-case load: REQ+gnt in cycle 1, WAIT+`rvalid` in cycle 2, `resp_valid` in cycle 3.
  - Error: `resp_valid`=`resp_err`=1 in cycle 1.
- `dram_rvalid` is earliest in the cycle after `dram_gnt`; it is never sampled in the grant cycle.
- `dram_*` outputs are registered and stable from entry into REQ until the grant cycle inclusive. They return to 0 the cycle after the grant.
- `resp_rdata` and `resp_err` are valid only while `resp_valid`=1. They hold their values until the next RESP.
- A new request may be accepted in the cycle after RESP, giving back-to-back stores every 3 cycles.
- `rst` in any state: the next cycle is IDLE with all outputs at reset values, and no `resp_valid` is issued for the aborted access. A `dram_rvalid` for the aborted access arriving later is ignored.

## Test plan
- st.b: `addr`=0x1003, `wdata`=0x000000A5, gnt immediate. Expect `dram_addr`=0x1000, `dram_we`=1000, `dram_wdata`=0xA5A5A5A5. `resp_valid` in cycle 2 with `resp_err`=0.
- ld.b then ld.bu at `addr`=0x2002, `dram_rdata`=0x12F45678. Expect `resp_rdata`=0xFFFFFFF4 (`RAM_EXT_B`) and 0x000000F4 (`RAM_EXT_BU`). Each `resp_valid` arrives in cycle 3.
- ld.h at 0x2002, `rdata`=0x80017FFF, gives 0xFFFF8001; ld.hu at 0x2000 gives 0x00007FFF. ld.w at 0x2000 returns 0x80017FFF unchanged.
- Misaligned ld.w at 0x3001 and st.h at 0x3003. Expect `dram_req` never asserted, `resp_valid`=`resp_err`=1 in cycle 1, `resp_rdata`=0.
- Grant held low 4 cycles, then `rvalid` 2 cycles after grant:
  - `dram_req` and `dram_addr` are stable throughout.
  - `stall`=1 from cycle 0 through WAIT, and 0 in RESP.
  - A `dram_rvalid` pulse injected during REQ is ignored.
- `rst` asserted while in WAIT, followed by a late `dram_rvalid`. Expect IDLE next cycle, no `resp_valid`, and the next ld.w completing normally.
